// File: rtl/pwm_pkg.sv
// Shared defaults, count-direction encoding and slice helper for the pwm_multi block.
package pwm_pkg;

  localparam int DEF_WIDTH  = 21;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  function automatic int ch_off(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: active duty register, compare against the shared counter, registered output.
module pwm_channel import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_new,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] duty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      // duty >= period is naturally 100% since cnt never exceeds period-1
      pwm <= run && en && (cnt < duty);
      if (load) duty <= duty_new;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter and shadowed period/duty loads.
// Optional center-aligned counting is built when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi import pwm_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    update_valid,
  output logic                    update_ready,
  input  logic [WIDTH-1:0]        period_in,
  input  logic [NUM_CH*WIDTH-1:0] duty_in,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    center_mode,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]        cnt, per, pend_per;
  logic [NUM_CH*WIDTH-1:0] pend_duty;
  logic                    pend, run, last, boundary, apply, ctr;
  dir_e                    dir;

  assign update_ready = !pend;
  assign run          = (per != '0);
  assign last         = (cnt == per - ONE);
  // idle (period 0) counts as a permanent boundary so the first load lands at once
  assign boundary     = !run || (ctr ? (dir == DOWN && cnt == '0) : last);
  assign apply        = pend && boundary;

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ctr <= 1'b0;
    else if (apply) ctr <= center_mode;
  end
`else
  logic unused_center;
  assign unused_center = center_mode;
  assign ctr           = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= 1'b0;
      pend_per  <= '0;
      pend_duty <= '0;
    end else if (update_valid && update_ready) begin
      pend      <= 1'b1;
      pend_per  <= period_in;
      pend_duty <= duty_in;
    end else if (apply) begin
      pend      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      dir <= UP;
      per <= '0;
    end else if (apply) begin
      cnt <= '0;
      dir <= UP;
      per <= pend_per;
    end else if (!run) begin
      cnt <= '0;
      dir <= UP;
    end else if (!ctr) begin
      cnt <= last ? '0 : cnt + ONE;
    end else if (dir == UP) begin
      // endpoints are held one extra cycle on each turnaround
      if (last) dir <= DOWN;
      else      cnt <= cnt + ONE;
    end else begin
      if (cnt == '0) dir <= UP;
      else           cnt <= cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) period_start <= 1'b0;
    else        period_start <= run && (cnt == '0) && (dir == UP);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (apply),
      .run      (run),
      .en       (ch_enable[i]),
      .duty_new (pend_duty[ch_off(i, WIDTH) +: WIDTH]),
      .cnt      (cnt),
      .pwm      (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_pwm_multi;

  localparam int W = 21;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           update_valid = 1'b0;
  logic           update_ready;
  logic [W-1:0]   period_in = '0;
  logic [N*W-1:0] duty_in = '0;
  logic [N-1:0]   ch_enable = '1;
  logic           center_mode = 1'b0;
  logic [N-1:0]   pwm_out;
  logic           period_start;

  typedef struct {
    logic [N-1:0] pwm;
    logic         ps;
    logic         rdy;
    int           id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  pwm_multi #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .update_valid (update_valid),
    .update_ready (update_ready),
    .period_in    (period_in),
    .duty_in      (duty_in),
    .ch_enable    (ch_enable),
    .center_mode  (center_mode),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // monitor: outputs are compared mid-cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pwm_out !== e.pwm || period_start !== e.ps || update_ready !== e.rdy) begin
        errors++;
        $display("FAIL cycle_%0d: got pwm=%b ps=%b rdy=%b, want pwm=%b ps=%b rdy=%b",
                 e.id, pwm_out, period_start, update_ready, e.pwm, e.ps, e.rdy);
      end
    end
  end

  task automatic cyc(input logic [N-1:0] p, input logic ps, input logic rdy);
    exp_t e;
    e.pwm = p; e.ps = ps; e.rdy = rdy; e.id = step;
    q.push_back(e);
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input int p, input int d3, input int d2, input int d1, input int d0);
    period_in = W'(p);
    duty_in   = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    update_valid = 1'b0;
    cyc(4'b0000, 1'b0, 1'b1);
    reset = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
  endtask

  // load from idle: accept, pending (ready low), applied, first output next cycle
  task automatic load_idle(input int p, input int d3, input int d2, input int d1, input int d0);
    set_vals(p, d3, d2, d1, d0);
    update_valid = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
    update_valid = 1'b0;
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;

    // basic waveforms: P=4, D={4,0,1,2}
    do_reset();
    ch_enable = 4'b1111;
    load_idle(4, 4, 0, 1, 2);
    repeat (3) begin
      cyc(4'b1011, 1'b1, 1'b1);
      cyc(4'b1001, 1'b0, 1'b1);
      cyc(4'b1000, 1'b0, 1'b1);
      cyc(4'b1000, 1'b0, 1'b1);
    end

    // shadowed load mid-period, then a second request while pending
    do_reset();
    load_idle(4, 4, 0, 0, 1);
    cyc(4'b1001, 1'b1, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    set_vals(8, 8, 0, 0, 6);
    update_valid = 1'b1;
    cyc(4'b1001, 1'b1, 1'b1);
    update_valid = 1'b0;
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1001, 1'b1, 1'b1);
    set_vals(2, 2, 0, 0, 1);
    update_valid = 1'b1;
    cyc(4'b1001, 1'b0, 1'b1);
    set_vals(16, 0, 0, 0, 12);
    cyc(4'b1001, 1'b0, 1'b0);
    update_valid = 1'b0;
    cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b1);
    repeat (2) begin
      cyc(4'b1001, 1'b1, 1'b1);
      cyc(4'b1000, 1'b0, 1'b1);
    end

    // reset mid-period, outputs stay low after release with no load
    do_reset();
    load_idle(8, 8, 0, 0, 5);
    cyc(4'b1001, 1'b1, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);

    // enable dropped mid-high-phase on channel 1 only
    do_reset();
    load_idle(4, 4, 1, 3, 2);
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1011, 1'b0, 1'b1);
    cyc(4'b1010, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1);
    ch_enable = 4'b1101;
    cyc(4'b1011, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1101, 1'b1, 1'b1);
    ch_enable = 4'b1111;
    cyc(4'b1001, 1'b0, 1'b1);
    cyc(4'b1010, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1);

    // center_mode requested: counts 0,1,2,3,3,2,1,0 when built in, else ignored
    do_reset();
    center_mode = 1'b1;
    load_idle(4, 4, 0, 0, 2);
`ifdef PWM_CENTER_ALIGN_EN
    cyc(4'b1001, 1'b1, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1);
    cyc(4'b1001, 1'b1, 1'b1);
`else
    repeat (2) begin
      cyc(4'b1001, 1'b1, 1'b1);
      cyc(4'b1001, 1'b0, 1'b1);
      cyc(4'b1000, 1'b0, 1'b1);
      cyc(4'b1000, 1'b0, 1'b1);
    end
    cyc(4'b1001, 1'b1, 1'b1);
`endif
    center_mode = 1'b0;

    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: got %0d checks, want at least 12", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0) $display("FAIL summary: got %0d errors, want 0", errors);
    else             $display("PASS");
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel PWM used by the music player.
- All channels share one period counter.
- Each channel has its own duty cycle and enable.
- Period and duty changes go through a valid/ready load interface into shadow registers and take effect only at a period boundary, so outputs are glitch-free.
- Drives tone/volume outputs for the player's voice mixer.

Parameters:
- WIDTH, 21: bit width of period, duty and the counter.
- NUM_CH, 4: number of PWM channels (1..16).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- update_valid  input  1  load request; one-cycle pulse or held.
- update_ready  output  1  high when a new load is accepted.
- period_in  input  WIDTH  new period, in cycles.
- duty_in  input  NUM_CH*WIDTH  new duties; channel i occupies bits [i*WIDTH +: WIDTH].
- ch_enable  input  NUM_CH  per-channel enable; live, not shadowed.
- center_mode  input  1  selects center-aligned counting; used only with PWM_CENTER_ALIGN_EN.
- pwm_out  output  NUM_CH  registered PWM outputs.
- period_start  output  1  one-cycle pulse on the first cycle of each period.

Behaviour:
- Reset (reset=0, asynchronous):
  - counter, active period, active duties, pending registers and pending flag cleared.
  - pwm_out=0, period_start=0, update_ready=1.
- Load handshake:
  - A transfer occurs when update_valid && update_ready.
  - On transfer, period_in and duty_in are captured into pending registers and pend=1.
  - update_ready = !pend.
  - update_valid while pend=1 is ignored; no queueing.
- Apply:
  - When pend=1 at the boundary cycle, pending values are copied to active and pend clears the next cycle.
  - The boundary cycle is the last count of the period: edge mode cnt==P-1; center mode, down phase at cnt==0.
  - If active period P==0 (idle), pending is applied on the next cycle.
  - A transfer in the same cycle as a boundary is not applied at that boundary; it waits for the next one.
- Edge mode counter:
  - cnt counts 0..P-1, then wraps to 0.
  - P==0: cnt held at 0, all pwm_out=0, no period_start.
- Compare:
  - pwm_out[i] registered; it reflects (ch_enable[i] && cnt < D[i]), evaluated on the previous cycle's cnt.
  - Latency is 1 cycle.
  - D==0 gives constant low; D>=P gives constant high (100%).
- period_start:
  - Registered pulse aligned with pwm_out; high in the output cycle corresponding to cnt==0 at the start of a period.
  - In center mode, asserted only at the start of the up phase.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - P=2^WIDTH-1 is the maximum.
  - The counter never exceeds P-1, so there is no overflow.
- Mid-operation reset returns to the reset state immediately. There is no partial period after reset release: cnt starts at 0 with P=0, so outputs stay low until the first load is applied.
- ch_enable deassert forces the channel low on the next output cycle. It does not disturb the counter or the other channels.

Optional Feature:
- PWM_CENTER_ALIGN_EN
- Defined: when center_mode=1, cnt runs up 0..P-1, then down P-1..0. Each endpoint appears twice, so the period is 2P cycles and the high time is 2D cycles, symmetric about the counter peak.
  - Load boundary is the final 0 of the down phase.
  - center_mode is sampled only at boundaries, together with the shadow apply.
- Not defined: center_mode is ignored and the block is edge-aligned only.

Decomposition:
- Package pwm_pkg holds:
  - default WIDTH and NUM_CH;
  - count-direction encoding (UP, DOWN);
  - a helper for the channel slice offset.
- Sub-module pwm_channel: per-channel active duty register, comparator and output flop; instantiated NUM_CH times in a generate loop.
- The top level owns the counter, direction state, shadow/pending logic and handshake.

Test Plan:
- Reset then load P=4, D={2,1,0,4}, all enabled:
  - pwm_out[0] repeats 1100; [1] repeats 1000; [2] stays 0; [3] stays 1.
  - period_start fires every 4 cycles.
- Running P=4, D0=1; load P=8, D0=6 when cnt==1:
  - update_ready drops.
  - The current 4-cycle period completes unchanged.
  - The next period is 8 cycles with 6 high.
  - update_ready returns 1 cycle after the apply.
- Second update_valid while pend=1 (P=16):
  - Ignored; only the first pending values are applied.
- Assert reset low mid-period with P=8, D0=5:
  - pwm_out=0 within the same cycle; update_ready=1.
  - After release, outputs stay 0 until a new load.
- Clear ch_enable[1] mid-high-phase:
  - pwm_out[1]=0 next cycle; other channels' waveforms are unchanged.
- With PWM_CENTER_ALIGN_EN, center_mode=1, P=4, D0=2:
  - cnt sequence 0,1,2,3,3,2,1,0.
  - pwm_out[0] pattern 11000011, an 8-cycle period.
